sort_result_unloader: RTL and testbench
=======================================

# sort_result_unloader

Downstream stage of the 8-word bubble sorter. It snapshots the sorter's eight parallel result words on a capture strobe and streams them out one word per transfer over a valid/ready handshake, lowest index first. On every capture it also checks ascending order and reports the number of out-of-order adjacent pairs. The check lets the sorter be verified in-system.

## Interface
Parameters:
- N, 8, number of words per frame (fixed at 8; ports A1..A8 are explicit)
- word_size, 4, bits per word

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  reset, asynchronous, active-low
- cap  input  1  capture strobe; sampled at rising edge of clk
- A1..A8  input  word_size each  sorter result words; A1 is the first position
- out_word  output  word_size  current word; 0 when out_valid=0
- out_valid  output  1  out_word is valid
- out_ready  input  1  consumer accepts the word
- out_idx  output  3  position of out_word, 0..N-1 (0 ↔ A1)
- out_last  output  1  out_valid && out_idx==N-1
- busy  output  1  frame in progress (state == S_send)
- sorted_ok  output  1  last captured frame was non-decreasing
- order_err  output  3  count of pairs with A(k) > A(k+1), k=1..7, in last captured frame
- overrun  output  1  sticky; a capture was rejected while busy

## Operation
- Internal buffer buf[0..N-1] of word_size bits. State register with two states: S_idle and S_send.
- Capture accepted when cap=1 and either:
  - state==S_idle, or
  - state==S_send with a final transfer in the same cycle (out_valid && out_ready && out_idx==N-1).
- On an accepted capture:
  - buf[k-1] <= Ak.
  - order_err <= sum over k=1..7 of (Ak > Ak+1), unsigned compare of the live inputs.
  - sorted_ok <= (that sum == 0).
  - overrun <= 0, out_idx <= 0, state <= S_send.
- cap=1 in S_send without a final transfer: capture rejected; buf, order_err and sorted_ok unchanged; overrun <= 1.
- S_send:
  - out_valid=1 and out_word=buf[out_idx].
  - Transfer = out_valid && out_ready at a rising edge.
  - On a transfer with out_idx<N-1: out_idx <= out_idx+1.
  - On a transfer with out_idx==N-1 and no accepted capture: state <= S_idle, out_idx <= 0.
- S_idle: out_valid=0, out_word=0, out_idx=0. out_ready is ignored.
- out_word, out_valid and out_last are driven combinationally from registered state and buf. There is no combinational path from out_ready or cap to any output.
- Maximum order_err is 7, so 3 bits suffice with no wrap.

## Timing
- Reset (rst=0, asynchronous):
  - state=S_idle, buf all 0, out_idx=0.
  - Outputs: out_valid=0, out_word=0, out_last=0, busy=0, sorted_ok=0, order_err=0, overrun=0.
  - Reset asserted mid-frame aborts the frame immediately, with no further transfers.
  - Release is synchronous-safe: the first capture is honoured on the first rising edge after rst goes high.
- Latency: cap accepted at edge t gives out_valid=1 with word A1 in cycle t+1. sorted_ok and order_err are also valid from t+1.
- Throughput: with out_ready held high, 8 words transfer on 8 consecutive edges.
- Back-to-back frames: a cap coinciding with the final transfer restarts the frame with zero bubble. out_valid stays 1 and the next word is the new A1.
- Backpressure: with out_ready=0, out_word and out_idx hold stable indefinitely. A1..A8 may change freely after capture.
- busy equals out_valid.

## Test plan
- Reset, then cap with A=1,1,1,1,8,8,8,8 and out_ready=1 → from the next cycle out_word=1,1,1,1,8,8,8,8 on 8 consecutive cycles, out_last only on the 8th; sorted_ok=1, order_err=0; busy falls after the 8th transfer.
- cap with A=8,1,8,1,8,1,8,1 → order_err=4, sorted_ok=0; stream is 8,1,8,1,8,1,8,1.
- Backpressure: A=1..8, toggle out_ready 1,0,0,1,… → each word is held while out_ready=0; the sequence 1..8 is delivered with no loss or duplication and out_idx matches the word.
- Overrun: after a capture of 8,7,6,5,4,3,2,1 (order_err=7), pulse cap with different A at transfer 3 → overrun=1 and the stream continues 8..1 unchanged. The next idle capture clears overrun to 0.
- Back-to-back: A=5,5,5,5,5,5,5,5 then cap with A=1..8 on the final-transfer cycle → out_valid never drops; 16 words out; sorted_ok=1 for both frames; overrun=0.
- Reset mid-frame: drive rst=0 asynchronously (between clock edges) at transfer 4 → out_valid, out_word, busy, sorted_ok and order_err go to 0 immediately. After release, a fresh cap restarts at A1.

Source files
------------

// File: rtl/sort_result_unloader.sv
// sort_result_unloader: snapshots eight sorter result words on cap and
// streams them out lowest index first over valid/ready, with order check.
// Ports: clk, rst (async active-low), cap, A1..A8 (result words),
//   out_word/out_valid/out_ready/out_idx/out_last (stream),
//   busy, sorted_ok, order_err (last frame check), overrun (sticky).
module sort_result_unloader #(
  parameter int N         = 8,
  parameter int word_size = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cap,
  input  logic [word_size-1:0] A1,
  input  logic [word_size-1:0] A2,
  input  logic [word_size-1:0] A3,
  input  logic [word_size-1:0] A4,
  input  logic [word_size-1:0] A5,
  input  logic [word_size-1:0] A6,
  input  logic [word_size-1:0] A7,
  input  logic [word_size-1:0] A8,
  output logic [word_size-1:0] out_word,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2:0]           out_idx,
  output logic                 out_last,
  output logic                 busy,
  output logic                 sorted_ok,
  output logic [2:0]           order_err,
  output logic                 overrun
);

  typedef enum logic {
    S_idle,
    S_send
  } state_t;

  state_t state, state_nx;

  logic [2:0] idx, idx_nx;
  logic [word_size-1:0] wbuf [N];

  logic       is_last;
  logic       xfer;
  logic       fin;
  logic       acc;
  logic       rej;
  logic [2:0] err_cnt;

  assign is_last = (idx == 3'(N - 1));
  assign xfer    = out_valid && out_ready;
  assign fin     = xfer && is_last;
  // A capture may ride on the final transfer of the running frame.
  assign acc     = cap && ((state == S_idle) || fin);
  assign rej     = cap && (state == S_send) && !fin;

  assign err_cnt = 3'(A1 > A2) + 3'(A2 > A3)
                 + 3'(A3 > A4) + 3'(A4 > A5)
                 + 3'(A5 > A6) + 3'(A6 > A7)
                 + 3'(A7 > A8);

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    unique case (1'b1)
      acc: begin
        state_nx = S_send;
        idx_nx   = '0;
      end
      xfer && !is_last: begin
        idx_nx = idx + 3'd1;
      end
      fin && !cap: begin
        state_nx = S_idle;
        idx_nx   = '0;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_idle;
      idx       <= '0;
      order_err <= '0;
      sorted_ok <= 1'b0;
      overrun   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        wbuf[i] <= '0;
      end
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (acc) begin
        wbuf[0]   <= A1;
        wbuf[1]   <= A2;
        wbuf[2]   <= A3;
        wbuf[3]   <= A4;
        wbuf[4]   <= A5;
        wbuf[5]   <= A6;
        wbuf[6]   <= A7;
        wbuf[7]   <= A8;
        order_err <= err_cnt;
        sorted_ok <= (err_cnt == 3'd0);
        overrun   <= 1'b0;
      end else if (rej) begin
        overrun <= 1'b1;
      end
    end
  end

  assign out_valid = (state == S_send);
  assign busy      = out_valid;
  assign out_idx   = idx;
  assign out_last  = out_valid && is_last;
  assign out_word  = out_valid ? wbuf[idx] : '0;

endmodule

// File: tb/tb_sort_result_unloader.sv
// tb_sort_result_unloader: randomized and directed frames checked against
// a queue-based model of the captured frame and its order count.
module tb_sort_result_unloader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cap;
  logic [3:0] a_in [8];
  logic [3:0] out_word;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       busy;
  logic       sorted_ok;
  logic [2:0] order_err;
  logic       overrun;

  int total = 0;
  int bad   = 0;

  logic [3:0] got [$];
  logic [3:0] exp [$];

  always #5 clk = ~clk;

  sort_result_unloader #(.N(8), .word_size(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .cap      (cap),
    .A1       (a_in[0]),
    .A2       (a_in[1]),
    .A3       (a_in[2]),
    .A4       (a_in[3]),
    .A5       (a_in[4]),
    .A6       (a_in[5]),
    .A7       (a_in[6]),
    .A8       (a_in[7]),
    .out_word (out_word),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_last (out_last),
    .busy     (busy),
    .sorted_ok(sorted_ok),
    .order_err(order_err),
    .overrun  (overrun)
  );

  // Reference: number of descending adjacent pairs in a frame.
  function automatic int ref_err(input logic [3:0] a [8]);
    int n = 0;
    for (int k = 0; k < 7; k++)
      if (a[k] > a[k+1]) n++;
    return n;
  endfunction

  function automatic int first_diff();
    if (got.size() != exp.size()) return -2;
    for (int i = 0; i < got.size(); i++)
      if (got[i] !== exp[i]) return i;
    return -1;
  endfunction

  task automatic scramble();
    for (int i = 0; i < 8; i++) a_in[i] = 4'($urandom_range(0, 15));
  endtask

  // Called at posedge+1; leaves at posedge+1 after the capture edge.
  task automatic capture(input logic [3:0] a [8]);
    a_in = a;
    cap  = 1'b1;
    @(posedge clk);
    #1;
    cap = 1'b0;
    scramble();
  endtask

  // Consume words while out_valid; optionally pulse cap with na when
  // out_idx first equals cap_at. perr counts protocol slips.
  task automatic drain(input int mode, input int cap_at,
                       input logic [3:0] na [8],
                       output int cyc, output int perr);
    logic       rdy;
    logic       stalled;
    logic [3:0] lastw;
    bit         capd;
    int         ph;
    got.delete();
    cyc = 0; perr = 0; ph = 0;
    stalled = 1'b0; lastw = '0; capd = 1'b0;
    while (out_valid === 1'b1 && cyc < 200) begin
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (ph % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ph++;
      out_ready = rdy;
      if (out_idx !== 3'(got.size() % 8)) perr++;
      if (out_last !== (out_idx == 3'd7)) perr++;
      if (busy !== 1'b1) perr++;
      if (stalled && out_word !== lastw) perr++;
      if (!capd && cap_at >= 0 && out_idx == 3'(cap_at)) begin
        a_in = na;
        cap  = 1'b1;
        capd = 1'b1;
      end else begin
        cap = 1'b0;
      end
      stalled = !rdy;
      lastw   = out_word;
      if (rdy) got.push_back(out_word);
      @(posedge clk);
      #1;
      cyc++;
    end
    out_ready = 1'b0;
    cap = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; cap = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 8; i++) a_in[i] = '0;
    #3;
    total++;
    if ({out_valid, out_word, out_last, busy, sorted_ok, order_err,
         overrun, out_idx} !== 16'd0) begin
      bad++;
      $display("FAIL reset_outputs: got v=%b w=%0d l=%b b=%b s=%b e=%0d o=%b i=%0d, required all 0",
               out_valid, out_word, out_last, busy, sorted_ok, order_err,
               overrun, out_idx);
    end
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_sorted();
    logic [3:0] a [8] = '{1, 1, 1, 1, 8, 8, 8, 8};
    logic [3:0] na [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int cyc, perr;
    capture(a);
    total++;
    if (out_valid !== 1'b1 || out_word !== 4'd1) begin
      bad++;
      $display("FAIL sorted_latency: got v=%b w=%0d, required v=1 w=1",
               out_valid, out_word);
    end
    total++;
    if (sorted_ok !== 1'b1 || order_err !== 3'd0) begin
      bad++;
      $display("FAIL sorted_flags: got ok=%b err=%0d, required ok=1 err=0",
               sorted_ok, order_err);
    end
    drain(0, -1, na, cyc, perr);
    exp.delete();
    foreach (a[i]) exp.push_back(a[i]);
    total++;
    if (first_diff() != -1) begin
      bad++;
      $display("FAIL sorted_words: got n=%0d diff=%0d, required n=8 diff=-1",
               got.size(), first_diff());
    end
    total++;
    if (cyc != 8 || perr != 0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL sorted_stream: got cyc=%0d perr=%0d busy=%b, required 8 0 0",
               cyc, perr, busy);
    end
  endtask

  task automatic test_unsorted();
    logic [3:0] a [8] = '{8, 1, 8, 1, 8, 1, 8, 1};
    logic [3:0] na [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int cyc, perr;
    capture(a);
    total++;
    if (order_err !== 3'd4 || sorted_ok !== 1'b0) begin
      bad++;
      $display("FAIL unsorted_flags: got err=%0d ok=%b, required err=4 ok=0",
               order_err, sorted_ok);
    end
    drain(0, -1, na, cyc, perr);
    exp.delete();
    foreach (a[i]) exp.push_back(a[i]);
    total++;
    if (first_diff() != -1 || perr != 0) begin
      bad++;
      $display("FAIL unsorted_words: got diff=%0d perr=%0d, required -1 0",
               first_diff(), perr);
    end
  endtask

  task automatic test_backpressure();
    logic [3:0] a [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    logic [3:0] na [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int cyc, perr;
    capture(a);
    drain(1, -1, na, cyc, perr);
    exp.delete();
    foreach (a[i]) exp.push_back(a[i]);
    total++;
    if (first_diff() != -1) begin
      bad++;
      $display("FAIL bp_words: got n=%0d diff=%0d, required n=8 diff=-1",
               got.size(), first_diff());
    end
    total++;
    if (perr != 0 || cyc != 22) begin
      bad++;
      $display("FAIL bp_hold: got perr=%0d cyc=%0d, required perr=0 cyc=22",
               perr, cyc);
    end
  endtask

  task automatic test_overrun();
    logic [3:0] a [8] = '{8, 7, 6, 5, 4, 3, 2, 1};
    logic [3:0] na [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    logic [3:0] b [8];
    int cyc, perr;
    capture(a);
    total++;
    if (order_err !== 3'd7) begin
      bad++;
      $display("FAIL ovr_err7: got %0d, required 7", order_err);
    end
    drain(0, 2, na, cyc, perr);
    exp.delete();
    foreach (a[i]) exp.push_back(a[i]);
    total++;
    if (first_diff() != -1 || perr != 0) begin
      bad++;
      $display("FAIL ovr_stream: got diff=%0d perr=%0d, required -1 0",
               first_diff(), perr);
    end
    total++;
    if (overrun !== 1'b1 || order_err !== 3'd7 || sorted_ok !== 1'b0) begin
      bad++;
      $display("FAIL ovr_sticky: got ovr=%b err=%0d ok=%b, required 1 7 0",
               overrun, order_err, sorted_ok);
    end
    for (int i = 0; i < 8; i++) b[i] = 4'($urandom_range(0, 15));
    capture(b);
    total++;
    if (overrun !== 1'b0 || order_err !== 3'(ref_err(b))) begin
      bad++;
      $display("FAIL ovr_clear: got ovr=%b err=%0d, required 0 %0d",
               overrun, order_err, ref_err(b));
    end
    drain(0, -1, na, cyc, perr);
  endtask

  task automatic test_back_to_back();
    logic [3:0] a [8] = '{5, 5, 5, 5, 5, 5, 5, 5};
    logic [3:0] na [8] = '{1, 2, 3, 4, 5, 6, 7, 8};
    int cyc, perr;
    capture(a);
    total++;
    if (sorted_ok !== 1'b1) begin
      bad++;
      $display("FAIL b2b_ok1: got %b, required 1", sorted_ok);
    end
    drain(0, 7, na, cyc, perr);
    exp.delete();
    foreach (a[i]) exp.push_back(a[i]);
    foreach (na[i]) exp.push_back(na[i]);
    total++;
    if (first_diff() != -1 || cyc != 16 || perr != 0) begin
      bad++;
      $display("FAIL b2b_stream: got n=%0d diff=%0d cyc=%0d perr=%0d, required 16 -1 16 0",
               got.size(), first_diff(), cyc, perr);
    end
    total++;
    if (sorted_ok !== 1'b1 || overrun !== 1'b0) begin
      bad++;
      $display("FAIL b2b_flags: got ok=%b ovr=%b, required 1 0",
               sorted_ok, overrun);
    end
  endtask

  task automatic test_reset_midframe();
    logic [3:0] a [8] = '{9, 3, 3, 12, 0, 15, 6, 6};
    logic [3:0] b [8];
    logic [3:0] na [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int cyc, perr;
    capture(a);
    out_ready = 1'b1;
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    total++;
    if (out_idx !== 3'd4 || out_word !== a[4]) begin
      bad++;
      $display("FAIL mid_pos: got idx=%0d w=%0d, required 4 %0d",
               out_idx, out_word, a[4]);
    end
    #2;
    rst = 1'b0;
    #1;
    total++;
    if ({out_valid, out_word, busy, sorted_ok, order_err} !== 10'd0) begin
      bad++;
      $display("FAIL mid_async: got v=%b w=%0d b=%b ok=%b err=%0d, required all 0",
               out_valid, out_word, busy, sorted_ok, order_err);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    total++;
    if (out_valid !== 1'b0) begin
      bad++;
      $display("FAIL mid_idle: got v=%b, required 0", out_valid);
    end
    for (int i = 0; i < 8; i++) b[i] = 4'($urandom_range(0, 15));
    capture(b);
    drain(0, -1, na, cyc, perr);
    exp.delete();
    foreach (b[i]) exp.push_back(b[i]);
    total++;
    if (first_diff() != -1 || perr != 0) begin
      bad++;
      $display("FAIL mid_restart: got diff=%0d perr=%0d, required -1 0",
               first_diff(), perr);
    end
  endtask

  task automatic test_random();
    logic [3:0] a [8];
    logic [3:0] na [8] = '{0, 0, 0, 0, 0, 0, 0, 0};
    int cyc, perr, e;
    for (int f = 0; f < 25; f++) begin
      for (int i = 0; i < 8; i++) a[i] = 4'($urandom_range(0, 15));
      if (f % 5 == 0) a.sort();
      e = ref_err(a);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      capture(a);
      total++;
      if (order_err !== 3'(e) || sorted_ok !== (e == 0)) begin
        bad++;
        $display("FAIL rnd_flags f=%0d: got err=%0d ok=%b, required %0d %b",
                 f, order_err, sorted_ok, e, e == 0);
      end
      drain(2, -1, na, cyc, perr);
      exp.delete();
      foreach (a[i]) exp.push_back(a[i]);
      total++;
      if (first_diff() != -1 || perr != 0 || out_word !== 4'd0) begin
        bad++;
        $display("FAIL rnd_stream f=%0d: got diff=%0d perr=%0d idle_w=%0d, required -1 0 0",
                 f, first_diff(), perr, out_word);
      end
    end
  endtask

  initial begin
    test_reset();
    test_sorted();
    test_unsorted();
    test_backpressure();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
